// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store controller between the execute stage and a byte-banked data RAM.
// Accepts one load or store per handshake, converts the byte address into a
// word address, and builds per-lane write enables and lane-aligned write data.
// Load data is extracted, then sign- or zero-extended into a registered
// response. An access that straddles a word boundary is split into two RAM
// cycles: FIRST handles word W and SECOND handles word W+1.
//
// Ports
//   clk, rst            clock (rising edge) and async active-high reset
//   clk_en              global stall; 0 holds all state and registered outputs
//   i_req_*/o_req_ready request handshake (we, size, unsigned, addr, wdata)
//   o_resp_*            one-cycle response pulse with extended data and error
//   o_mem_read_*        RAM read strobe/word address; i_mem_read_data is
//                       combinational from o_mem_read_addr
//   o_mem_write_*       RAM write strobe, lane enables, word address, data
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH:0]   i_req_addr,
  input  logic [DATA_WIDTH:0]   i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH:0]   o_resp_rdata,
  output logic                  o_resp_err,
  output logic                  o_mem_read_req,
  output logic [ADDR_WIDTH:0]   o_mem_read_addr,
  input  logic [DATA_WIDTH:0]   i_mem_read_data,
  output logic                  o_mem_write_enable,
  output logic [3:0]            o_mem_byte_enable,
  output logic [ADDR_WIDTH:0]   o_mem_write_addr,
  output logic [DATA_WIDTH:0]   o_mem_write_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FIRST  = 2'b01,
    ST_SECOND = 2'b10,
    ST_RESP   = 2'b11
  } state_t;

  state_t                state_r;
  state_t                state_s;

  logic                  we_r;
  logic [1:0]            size_r;
  logic                  uns_r;
  logic [1:0]            off_r;
  logic [ADDR_WIDTH:0]   word_r;
  logic [DATA_WIDTH:0]   wdata_r;
  logic [DATA_WIDTH:0]   lo_r;
  logic [DATA_WIDTH:0]   rdata_r;
  logic                  err_r;

  logic                  accept_s;
  logic [7:0]            base_mask_s;
  logic [7:0]            mask8_s;
  logic [63:0]           data64_s;
  logic                  cross_s;
  logic [ADDR_WIDTH:0]   word_hi_s;
  logic [DATA_WIDTH:0]   resp_data_s;
  logic                  resp_err_s;

  // Shift the {HI,LO} pair down by the byte offset, keep the access size and
  // extend it to a full word.
  function automatic logic [31:0] extend_load(input logic [63:0] pair,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [63:0] sh;
    logic [31:0] res;
    sh = pair >> {off, 3'b000};
    case (size)
      2'b00:   res = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      2'b10:   res = sh[31:0];
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Ready only in IDLE and never while reset is asserted.
  assign o_req_ready  = (state_r == ST_IDLE) && !rst;
  assign accept_s     = i_req_valid && o_req_ready;
  assign o_resp_valid = (state_r == ST_RESP);
  assign o_resp_rdata = rdata_r;
  assign o_resp_err   = err_r;

  // Lane mask, shifted store data and the wrapped upper word address.
  always_comb begin
    case (size_r)
      2'b00:   base_mask_s = 8'b0000_0001;
      2'b01:   base_mask_s = 8'b0000_0011;
      2'b10:   base_mask_s = 8'b0000_1111;
      default: base_mask_s = 8'b0000_0000;
    endcase
    mask8_s  = base_mask_s << off_r;
    data64_s = {32'h0000_0000, wdata_r} << {off_r, 3'b000};
    cross_s  = |mask8_s[7:4];
    // The word address space is ADDR_WIDTH-1 bits wide, so W+1 wraps to 0.
    word_hi_s = {(ADDR_WIDTH+1){1'b0}};
    word_hi_s[ADDR_WIDTH-2:0] = word_r[ADDR_WIDTH-2:0] + {{(ADDR_WIDTH-2){1'b0}}, 1'b1};
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (i_req_size == 2'b11) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_FIRST;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FIRST: begin
        if (cross_s) begin
          state_s = ST_SECOND;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_SECOND: state_s = ST_RESP;
      ST_RESP:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // RAM port drive: active only in FIRST/SECOND, zero everywhere else.
  always_comb begin
    o_mem_read_req     = 1'b0;
    o_mem_read_addr    = {(ADDR_WIDTH+1){1'b0}};
    o_mem_write_enable = 1'b0;
    o_mem_byte_enable  = 4'b0000;
    o_mem_write_addr   = {(ADDR_WIDTH+1){1'b0}};
    o_mem_write_data   = {(DATA_WIDTH+1){1'b0}};
    case (state_r)
      ST_FIRST: begin
        if (we_r) begin
          o_mem_write_enable = 1'b1;
          o_mem_byte_enable  = mask8_s[3:0];
          o_mem_write_addr   = word_r;
          o_mem_write_data   = data64_s[31:0];
        end else begin
          o_mem_read_req     = 1'b1;
          o_mem_read_addr    = word_r;
        end
      end
      ST_SECOND: begin
        if (we_r) begin
          o_mem_write_enable = 1'b1;
          o_mem_byte_enable  = mask8_s[7:4];
          o_mem_write_addr   = word_hi_s;
          o_mem_write_data   = data64_s[63:32];
        end else begin
          o_mem_read_req     = 1'b1;
          o_mem_read_addr    = word_hi_s;
        end
      end
      default: begin
        o_mem_read_req     = 1'b0;
      end
    endcase
  end

  // Response value to load when entering RESP; the final RAM word is used
  // straight from the bus so no extra capture cycle is needed.
  always_comb begin
    resp_data_s = {(DATA_WIDTH+1){1'b0}};
    resp_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Entering RESP directly from IDLE only happens for an illegal size.
        resp_err_s = 1'b1;
      end
      ST_FIRST: begin
        if (we_r) begin
          resp_data_s = {(DATA_WIDTH+1){1'b0}};
        end else begin
          resp_data_s = extend_load({32'h0000_0000, i_mem_read_data}, off_r, size_r, uns_r);
        end
      end
      ST_SECOND: begin
        if (we_r) begin
          resp_data_s = {(DATA_WIDTH+1){1'b0}};
        end else begin
          resp_data_s = extend_load({i_mem_read_data, lo_r}, off_r, size_r, uns_r);
        end
      end
      default: begin
        resp_err_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else if (clk_en) begin
      state_r <= state_s;
    end
  end

  // Request capture, lower-word load capture and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      off_r   <= 2'b00;
      word_r  <= {(ADDR_WIDTH+1){1'b0}};
      wdata_r <= {(DATA_WIDTH+1){1'b0}};
      lo_r    <= {(DATA_WIDTH+1){1'b0}};
      rdata_r <= {(DATA_WIDTH+1){1'b0}};
      err_r   <= 1'b0;
    end else if (clk_en) begin
      if (accept_s) begin
        we_r    <= i_req_we;
        size_r  <= i_req_size;
        uns_r   <= i_req_unsigned;
        off_r   <= i_req_addr[1:0];
        word_r  <= {2'b00, i_req_addr[ADDR_WIDTH:2]};
        wdata_r <= i_req_wdata;
      end
      if ((state_r == ST_FIRST) && !we_r) begin
        lo_r <= i_mem_read_data;
      end
      if ((state_s == ST_RESP) && (state_r != ST_RESP)) begin
        rdata_r <= resp_data_s;
        err_r   <= resp_err_s;
      end
    end
  end

endmodule
